// File: rtl/npu_bitplane_accumulator_pkg.sv
// Shared NPU package for the bit-plane accumulator.
// Holds the accumulator FSM state encoding, the largest legal ones-count of a
// 3x3 window (CNT_MAX), and the rule for sizing the result from the plane count.
package npu_bitplane_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int CNT_MAX = 9;

    // Five extra bits hold 9 * (2^bits - 1) unsigned, and the same magnitude
    // range plus a sign bit in two's-complement mode.
    function automatic int acc_width(input int bits);
        return bits + 5;
    endfunction

endpackage

// File: rtl/npu_bitplane_accumulator_plane_counter.sv
// npu_plane_counter: modulo-BITS count of the planes accepted in the current window.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : synchronous return to zero (window abort)
//   inc        : one plane accepted this cycle
//   tc         : terminal count; the next accepted plane completes the window
module npu_plane_counter #(
    parameter int BITS = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // With BITS=1 the count never leaves zero and tc is permanently high.
    assign tc = (cnt_q == CW'(BITS - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/npu_bitplane_accumulator.sv
// npu_bitplane_accumulator: combines BITS MSB-first bit-plane ones-counts into one
// dot-product by shift-and-add. In signed mode the MSB plane carries negative
// weight. The result is presented through a registered valid/ready stage.
// Ports:
//   clk, rst_n          : clock and asynchronous active-low reset
//   in_valid / in_ready : plane handshake; in_ready is low only while a result is held
//   in_cnt              : ones-count of the plane (0..9, larger values saturate and set err)
//   in_signed           : signed mode, sampled with the first plane of a window
//   clear               : synchronous abort of a partial window (ignored in HOLD)
//   out_valid/out_ready : result handshake
//   out_data            : ACC_W-bit two's-complement result
//   err                 : sticky, an out-of-range count was accepted
//
// state | meaning
// IDLE  | no plane of the current window accepted yet
// ACCUM | 1..BITS-1 planes accepted, acc holds the partial sum
// HOLD  | result valid in out_data, waiting for out_ready
module npu_bitplane_accumulator
    import npu_bitplane_accumulator_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int ACC_W = acc_width(BITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_cnt,
    input  logic             in_signed,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             err
);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;

    logic             take;
    logic             last_plane;
    logic             cnt_over;
    logic [3:0]       cnt_sat;
    logic [ACC_W-1:0] cnt_ext;
    logic [ACC_W-1:0] acc_next;

    assign in_ready = (state_q != HOLD);
    // clear wins over a same-cycle plane, so the plane is not taken at all.
    assign take     = in_valid & in_ready & ~clear;
    assign cnt_over = (in_cnt > 4'(CNT_MAX));
    assign cnt_sat  = cnt_over ? 4'(CNT_MAX) : in_cnt;
    assign cnt_ext  = ACC_W'(cnt_sat);

    // Negating only the MSB plane and then doubling it BITS-1 times gives it
    // the -2^(BITS-1) weight, so the sign needs no storage beyond the first plane.
    always_comb begin
        if (state_q == IDLE) begin
            acc_next = in_signed ? (ACC_W'(0) - cnt_ext) : cnt_ext;
        end else begin
            acc_next = {acc_q[ACC_W-2:0], 1'b0} + cnt_ext;
        end
    end

    npu_plane_counter #(
        .BITS (BITS)
    ) u_plane_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear & in_ready),
        .inc   (take),
        .tc    (last_plane)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        err_d       = err_q | (take & cnt_over);
        case (state_q)
            IDLE, ACCUM: begin
                if (clear) begin
                    state_d = IDLE;
                    acc_d   = '0;
                end else if (take) begin
                    acc_d = acc_next;
                    if (last_plane) begin
                        state_d     = HOLD;
                        out_data_d  = acc_next;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_npu_bitplane_accumulator.sv
module tb_npu_bitplane_accumulator;

    localparam int BITS  = 8;
    localparam int ACC_W = 13;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic [3:0]       in_cnt    = 4'd0;
    logic             in_signed = 1'b0;
    logic             clear     = 1'b0;
    logic             out_ready = 1'b1;
    logic             in_ready;
    logic             out_valid;
    logic [ACC_W-1:0] out_data;
    logic             err;

    int               n_cmp = 0;
    int               n_bad = 0;
    logic [ACC_W-1:0] exp_q[$];
    int               pl[BITS];
    int               w0;

    always #5 clk = ~clk;

    npu_bitplane_accumulator #(
        .BITS  (BITS),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cnt    (in_cnt),
        .in_signed (in_signed),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Weighted-sum reference: plane i has weight 2^(BITS-1-i); the MSB plane
    // weight is negative in signed mode. Counts above 9 saturate.
    function automatic logic [ACC_W-1:0] model(input logic s);
        int v;
        v = 0;
        for (int i = 0; i < BITS; i++) begin
            int c;
            c = (pl[i] > 9) ? 9 : pl[i];
            if (s && i == 0) v -= c * (1 << (BITS - 1));
            else             v += c * (1 << (BITS - 1 - i));
        end
        return ACC_W'(v);
    endfunction

    // Entered and left at posedge+1; returns how many cycles in_ready made it wait.
    task automatic send_plane(input int c, input logic s, output int waited);
        int n;
        n = 0;
        in_valid  = 1'b1;
        in_cnt    = 4'(c);
        in_signed = s;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("in_ready_timeout", 32'(in_ready), 1);
        @(posedge clk); #1;
        waited = n;
    endtask

    task automatic window(input logic s, output int first_wait);
        int w;
        exp_q.push_back(model(s));
        for (int i = 0; i < BITS; i++) begin
            send_plane(pl[i], s, w);
            if (i == 0) first_wait = w;
        end
        in_valid = 1'b0;
    endtask

    // Scoreboard side: a result is taken on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check("out_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        int w;

        #12;
        check("rst_in_ready",  32'(in_ready),  1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data",  32'(out_data),  0);
        check("rst_err",       32'(err),       0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // unsigned all-nines: 2295, one-cycle pulse right after the last plane
        pl = '{9, 9, 9, 9, 9, 9, 9, 9};
        window(1'b0, w0);
        check("lat_valid",      32'(out_valid), 1);
        check("lat_in_ready",   32'(in_ready),  0);
        check("lat_value",      32'(out_data),  32'(13'd2295));
        @(posedge clk); #1;
        check("pulse_valid",    32'(out_valid), 0);
        check("pulse_in_ready", 32'(in_ready),  1);

        // signed MSB-only: -1152
        pl = '{9, 0, 0, 0, 0, 0, 0, 0};
        window(1'b1, w0);
        check("signed_neg", 32'(out_data), 32'(13'h1B80));
        @(posedge clk); #1;

        // signed, all but MSB: 1143
        pl = '{0, 9, 9, 9, 9, 9, 9, 9};
        window(1'b1, w0);
        check("signed_pos", 32'(out_data), 32'(13'd1143));
        @(posedge clk); #1;

        // backpressure for 5 cycles
        out_ready = 1'b0;
        pl = '{3, 1, 4, 1, 5, 9, 2, 6};
        window(1'b0, w0);
        for (int k = 0; k < 5; k++) begin
            check("hold_valid",    32'(out_valid), 1);
            check("hold_in_ready", 32'(in_ready),  0);
            check("hold_data",     32'(out_data),  32'(model(1'b0)));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        pl = '{7, 0, 2, 9, 1, 8, 3, 4};
        window(1'b1, w0);
        check("resume_wait", 32'(w0), 1);
        @(posedge clk); #1;

        // abort after 3 planes; the out-of-range count alongside clear is dropped
        for (int i = 0; i < 3; i++) send_plane(9, 1'b0, w);
        clear  = 1'b1;
        in_cnt = 4'd12;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("clear_no_out",   32'(out_valid), 0);
        check("clear_in_ready", 32'(in_ready),  1);
        check("clear_no_err",   32'(err),       0);
        pl = '{1, 2, 3, 4, 5, 6, 7, 8};
        window(1'b0, w0);
        @(posedge clk); #1;

        // out-of-range count saturates to 9 and sets err
        pl = '{0, 0, 0, 12, 0, 0, 0, 0};
        window(1'b0, w0);
        check("err_value", 32'(out_data), 32'(13'd144));
        check("err_set",   32'(err),      1);
        @(posedge clk); #1;
        check("err_sticky", 32'(err), 1);

        // asynchronous reset mid-window
        for (int i = 0; i < 4; i++) send_plane(5, 1'b1, w);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  32'(in_ready),  1);
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_out_data",  32'(out_data),  0);
        check("mid_rst_err",       32'(err),       0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        pl = '{2, 9, 0, 4, 6, 1, 9, 3};
        window(1'b0, w0);
        @(posedge clk); #1;

        // back-to-back random windows
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < BITS; i++) pl[i] = int'($urandom_range(0, 9));
            window(1'($urandom_range(0, 1)), w0);
        end

        for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        check("drain", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/npu_bitplane_accumulator.md
# npu_bitplane_accumulator

- Bit-serial accumulator that sits directly downstream of the 9-input ones-counter in the NPU convolution datapath.
- Each cycle it accepts one 4-bit ones-count: the number of set products across a 3x3 window for one weight/activation bit-plane.
- Planes arrive MSB-first. The block combines BITS planes by shift-and-add, applying two's-complement weighting to the MSB plane in signed mode.
- It emits one dot-product result per window through a valid/ready output stage.

## Interface
- BITS, default 8: number of bit-planes per result (2..16).
- ACC_W, default BITS+5: result width, two's complement.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  plane count present.
- in_ready  out  1  block accepts the plane this cycle.
- in_cnt  in  4  ones-count of current plane; legal range 0..9.
- in_signed  in  1  signed mode; sampled only with the first plane of a window.
- clear  in  1  synchronous abort of any partial window.
- out_valid  out  1  result held in out_data.
- out_ready  in  1  consumer takes the result.
- out_data  out  ACC_W  accumulated dot-product.
- err  out  1  sticky flag: an in_cnt > 9 was accepted.

## Operation
- States:
  - IDLE: no plane accepted yet.
  - ACCUM: 1..BITS-1 planes accepted.
  - HOLD: result valid.
- Transfer occurs on in_valid & in_ready.
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD.
- First plane (IDLE transfer):
  - sign_q <= in_signed.
  - acc <= sign_q_new ? -cnt : +cnt.
  - plane_cnt <= 1; go to ACCUM.
- Subsequent planes: acc <= 2*acc + cnt; plane_cnt increments.
- The BITS-th transfer computes the final acc, loads it into out_data, sets out_valid, and goes to HOLD.
- HOLD: out_data and out_valid stay constant until out_valid & out_ready, then out_valid <= 0 and state returns to IDLE.
- cnt = min(in_cnt, 9). An accepted in_cnt > 9 sets err, which stays set until reset.
- Arithmetic is full ACC_W signed with no overflow; ACC_W = BITS+5 covers both ranges:
  - unsigned: 0..9*(2^BITS-1)
  - signed: -9*2^(BITS-1)..9*(2^(BITS-1)-1)
- clear = 1:
  - In IDLE/ACCUM: discards acc, sets plane_cnt <= 0, state IDLE; any same-cycle input transfer is ignored.
  - In HOLD: no effect; an issued result is never dropped.
- With BITS=1, the first plane is also the last and the block goes straight to HOLD.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, err=0; internally state=IDLE, acc=0, plane_cnt=0.
- Reset mid-window discards all partial state immediately, asynchronously.
- Latency: out_valid rises in the cycle after the edge that accepted the BITS-th plane.
- Throughput: at most one result per BITS+1 cycles, reached when out_ready=1 continuously.
- Bubbles: in_valid low during ACCUM simply stalls; plane_cnt and acc hold.
- Backpressure: out_ready low in HOLD keeps in_ready low indefinitely.
- Next window: its first plane can be accepted in the cycle after the output transfer.
- All outputs are registered; there are no combinational paths from in_* to out_*. in_ready depends only on state.

## Structure
- Shared NPU package holds:
  - state enum {IDLE, ACCUM, HOLD};
  - constant CNT_MAX = 9;
  - function acc_width(bits) = bits+5.
- Optional sub-module npu_plane_counter: a BITS-modulo plane counter with a terminal-count flag.
- Everything else (FSM, datapath, output register) stays in one module.

## Test plan
- BITS=8, unsigned, eight planes in_cnt=9, out_ready=1: out_data=2295; out_valid high exactly one cycle, 9 cycles after the first transfer.
- Signed, MSB plane 9 then seven planes 0: out_data = -1152 (ACC_W=13 two's complement).
- Signed, planes 0,9,9,9,9,9,9,9: out_data = 1143.
- Result in HOLD with out_ready=0 for 5 cycles: out_data stable, in_ready=0. After out_ready=1, the next window's first plane is accepted the following cycle.
- Fault and abort:
  - in_cnt=12 on one plane of an otherwise zero unsigned window: err=1, plane treated as 9.
  - clear asserted after 3 planes: no output, the next window computes from scratch.
- rst_n pulsed low after 4 planes: all outputs at reset values; a subsequent full window produces the correct result with no residue.
